ppu_cpu_driver: RTL and testbench

Parametrised CPU-side bus driver for PPU bring-up and scroll testing. It runs a checked init sequence: PPUCTRL write with readback and bounded retry, then a PPUMASK write. After that it performs a per-frame vblank service on each NMI: status read, PPUCTRL with nametable select, and two scroll writes. Scroll position uses signed per-axis velocity, NES-correct Y wrap at 240, nametable toggling and a frame divider. It sits in place of the CPU in PPU simulation and FPGA demo tops, driving the $2000–$2007 register port.

---
 rtl/ppu_cpu_driver_if.sv | 17 +
 rtl/ppu_cpu_driver.sv | 200 ++++++++++++++++++++
 tb/tb_ppu_cpu_driver.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_cpu_driver_if.sv
// CPU-side PPU register bus ($2000-$2007).
// The driver is the master; the PPU model or real PPU is the slave.
interface ppu_cpu_driver_if;
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data_o;
    logic [7:0]  data_i;

    modport master (
        output rw, addr, data_o,
        input  data_i
    );
    modport slave (
        input  rw, addr, data_o,
        output data_i
    );
endinterface

// File: rtl/ppu_cpu_driver.sv
// CPU stand-in for PPU bring-up: checked CTRL/MASK init, then a
// per-NMI vblank service writing nametable select and scroll.
module ppu_cpu_driver #(
    parameter logic [7:0] CTRL_VALUE   = 8'h90,
    parameter logic [7:0] MASK_VALUE   = 8'h1E,
    parameter int         SCROLLX_STEP = 3,
    parameter int         SCROLLY_STEP = 0,
    parameter int         FRAME_DIV    = 1,
    parameter int         MAX_RETRY    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             nmi,
    input  logic             pause,
    ppu_cpu_driver_if.master bus,
    output logic             ready,
    output logic             error,
    output logic [15:0]      frame_cnt
);

    typedef enum logic [3:0] {
        INIT_WR, INIT_RD, INIT_MASK, IDLE,
        VB_STATUS, VB_CTRL, VB_SX, VB_SY, ERROR
    } state_t;

    localparam logic signed [9:0] X_STEP    = 10'(SCROLLX_STEP);
    localparam logic signed [9:0] Y_STEP    = 10'(SCROLLY_STEP);
    localparam logic [7:0]        DIV_MAX   = 8'(FRAME_DIV - 1);
    localparam logic [7:0]        RETRY_LIM = 8'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [7:0]  retry_q, retry_d;
    logic        ready_q, ready_d;
    logic        error_q, error_d;
    logic [15:0] frame_q, frame_d;
    logic [7:0]  div_q, div_d;
    logic [7:0]  sx_q, sx_d;
    logic [7:0]  sy_q, sy_d;
    logic        ntx_q, ntx_d;
    logic        nty_q, nty_d;
    logic        pend_q, pend_d;
    logic        nmi_q;

    logic              nmi_re;
    logic              launch;
    logic signed [9:0] xs, ys, ys_hi, ys_lo;

    assign nmi_re = nmi & ~nmi_q & ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT_WR;
            retry_q <= 8'd0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            frame_q <= 16'd0;
            div_q   <= 8'd0;
            sx_q    <= 8'd0;
            sy_q    <= 8'd0;
            ntx_q   <= CTRL_VALUE[0];
            nty_q   <= CTRL_VALUE[1];
            pend_q  <= 1'b0;
            nmi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            ready_q <= ready_d;
            error_q <= error_d;
            frame_q <= frame_d;
            div_q   <= div_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            ntx_q   <= ntx_d;
            nty_q   <= nty_d;
            pend_q  <= pend_d;
            nmi_q   <= nmi;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        ready_d = ready_q;
        error_d = error_q;
        launch  = 1'b0;
        unique case (state_q)
            INIT_WR:   state_d = INIT_RD;
            INIT_RD: begin
                if (bus.data_i == CTRL_VALUE) begin
                    state_d = INIT_MASK;
                end else begin
                    retry_d = retry_q + 8'd1;
                    if (MAX_RETRY != 0 && retry_d == RETRY_LIM) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d = INIT_WR;
                    end
                end
            end
            INIT_MASK: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            // VB_SY chains straight into the next frame with no idle gap
            IDLE, VB_SY: begin
                if (pend_q || nmi_re) begin
                    state_d = VB_STATUS;
                    launch  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            VB_STATUS: state_d = VB_CTRL;
            VB_CTRL:   state_d = VB_SX;
            VB_SX:     state_d = VB_SY;
            ERROR:     state_d = ERROR;
            default:   state_d = INIT_WR;
        endcase
    end

    always_comb begin
        pend_d  = pend_q;
        frame_d = frame_q;
        div_d   = div_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        ntx_d   = ntx_q;
        nty_d   = nty_q;
        xs      = $signed({2'b00, sx_q}) + X_STEP;
        ys      = $signed({2'b00, sy_q}) + Y_STEP;
        ys_hi   = ys - 10'sd240;
        ys_lo   = ys + 10'sd240;
        if (launch) begin
            pend_d  = 1'b0;
            frame_d = frame_q + 16'd1;
            div_d   = (div_q == DIV_MAX) ? 8'd0 : div_q + 8'd1;
            if (div_d == 8'd0 && !pause) begin
                sx_d  = xs[7:0];
                ntx_d = ntx_q ^ (xs > 10'sd255 || xs < 10'sd0);
                if (ys >= 10'sd240) begin
                    sy_d  = ys_hi[7:0];
                    nty_d = ~nty_q;
                end else if (ys < 10'sd0) begin
                    sy_d  = ys_lo[7:0];
                    nty_d = ~nty_q;
                end else begin
                    sy_d  = ys[7:0];
                end
            end
        end else if (nmi_re) begin
            pend_d = 1'b1;
        end
    end

    always_comb begin
        bus.rw     = 1'b1;
        bus.addr   = 16'h0000;
        bus.data_o = 8'h00;
        unique case (state_q)
            INIT_WR: begin
                bus.rw     = 1'b0;
                bus.addr   = 16'h2000;
                bus.data_o = CTRL_VALUE;
            end
            INIT_RD:   bus.addr = 16'h2000;
            INIT_MASK: begin
                bus.rw     = 1'b0;
                bus.addr   = 16'h2001;
                bus.data_o = MASK_VALUE;
            end
            VB_STATUS: bus.addr = 16'h2002;
            VB_CTRL: begin
                bus.rw     = 1'b0;
                bus.addr   = 16'h2000;
                bus.data_o = {CTRL_VALUE[7:2], nty_q, ntx_q};
            end
            VB_SX: begin
                bus.rw     = 1'b0;
                bus.addr   = 16'h2005;
                bus.data_o = sx_q;
            end
            VB_SY: begin
                bus.rw     = 1'b0;
                bus.addr   = 16'h2005;
                bus.data_o = sy_q;
            end
            default: begin
                bus.rw     = 1'b1;
                bus.addr   = 16'h0000;
                bus.data_o = 8'h00;
            end
        endcase
    end

    assign ready     = ready_q;
    assign error     = error_q;
    assign frame_cnt = frame_q;

endmodule

// File: tb/tb_ppu_cpu_driver.sv
// Scoreboard bench for ppu_cpu_driver: a frame-level scroll model
// predicts every bus cycle, a monitor checks what the DUT drives.
module tb_ppu_cpu_driver;

    localparam logic [7:0] CTRL = 8'h90;
    localparam logic [7:0] MASK = 8'h1E;
    localparam int XS = 3;
    localparam int YS = -5;
    localparam int FD = 2;
    localparam int MR = 3;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
        logic [15:0] frame;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nmi = 1'b0;
    logic        pause = 1'b0;
    logic        ready, error;
    logic [15:0] frame_cnt;

    ppu_cpu_driver_if bus ();

    ppu_cpu_driver #(
        .CTRL_VALUE(CTRL), .MASK_VALUE(MASK),
        .SCROLLX_STEP(XS), .SCROLLY_STEP(YS),
        .FRAME_DIV(FD), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .nmi(nmi), .pause(pause),
        .bus(bus.master),
        .ready(ready), .error(error), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // PPU model: keeps the last CTRL write, corrupts the first nbad readbacks
    int         nbad = 0;
    int         rd_cnt;
    logic [7:0] ppu_ctrl;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt   <= 0;
            ppu_ctrl <= 8'h00;
        end else begin
            if (!bus.rw && bus.addr == 16'h2000) ppu_ctrl <= bus.data_o;
            if (bus.rw && bus.addr == 16'h2000) rd_cnt <= rd_cnt + 1;
        end
    end
    assign bus.data_i = (rd_cnt < nbad) ? 8'h00 : ppu_ctrl;

    int   n_cmp = 0;
    int   n_bad = 0;
    txn_t q[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.rw == 1'b0 || bus.addr != 16'h0000)) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_txn: got rw=%b addr=%h data=%h expected none (cycle %0d)",
                         bus.rw, bus.addr, bus.data_o, cyc);
            end else begin
                txn_t e;
                e = q.pop_front();
                chk("bus", {7'd0, bus.rw, bus.addr, bus.data_o}, {7'd0, e.rw, e.addr, e.data});
                chk("cycle", cyc, e.cyc);
                chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, e.frame});
            end
        end
    end

    int m_frame, m_div, m_x, m_y;
    bit m_ntx, m_nty;

    task automatic model_reset();
        m_frame = 0; m_div = 0; m_x = 0; m_y = 0;
        m_ntx = CTRL[0]; m_nty = CTRL[1];
    endtask

    task automatic push(logic rw, logic [15:0] a, logic [7:0] d, int c);
        txn_t t;
        t.rw = rw; t.addr = a; t.data = d; t.cyc = c;
        t.frame = 16'(m_frame);
        q.push_back(t);
    endtask

    task automatic model_launch(int lc, bit p);
        int s;
        m_frame = (m_frame + 1) % 65536;
        m_div = (m_div + 1) % FD;
        if (m_div == 0 && !p) begin
            s = m_x + XS;
            if (s > 255 || s < 0) m_ntx = ~m_ntx;
            m_x = s & 255;
            s = m_y + YS;
            if (s >= 240) begin s -= 240; m_nty = ~m_nty; end
            else if (s < 0) begin s += 240; m_nty = ~m_nty; end
            m_y = s;
        end
        push(1'b1, 16'h2002, 8'h00, lc + 1);
        push(1'b0, 16'h2000, {CTRL[7:2], m_nty, m_ntx}, lc + 2);
        push(1'b0, 16'h2005, 8'(m_x), lc + 3);
        push(1'b0, 16'h2005, 8'(m_y), lc + 4);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        @(negedge clk);
        chk("rst_bus", {7'd0, bus.rw, bus.addr, bus.data_o}, {8'd0, 16'h2000, CTRL});
        chk("rst_ready", ready, 0);
        chk("rst_error", error, 0);
        chk("rst_frame", frame_cnt, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        nmi = 1'b0;
        q.delete();
        tick();
        tick();
        check_reset_vals();
    endtask

    task automatic do_init(int nb);
        int k, fails;
        nbad = nb;
        tick();
        rst_n = 1'b1;
        model_reset();
        k = cyc;
        fails = 0;
        while (1) begin
            push(1'b0, 16'h2000, CTRL, k);
            push(1'b1, 16'h2000, 8'h00, k + 1);
            k += 2;
            if (fails < nb) begin
                fails++;
                if (fails == MR) break;
            end else begin
                push(1'b0, 16'h2001, MASK, k);
                break;
            end
        end
        if (nb > 0) begin
            tick(); nmi = 1'b1;
            tick(); nmi = 1'b0;
            tick(); nmi = 1'b1;
            tick(); nmi = 1'b0;
        end
        while (cyc < k + 3) tick();
    endtask

    task automatic frame_pulse(bit p, int gap);
        pause = p;
        nmi = 1'b1;
        model_launch(cyc, p);
        tick();
        nmi = 1'b0;
        repeat (gap) tick();
    endtask

    // edges at n, n+2 (pending) and n+4 (dropped): two frames
    task automatic burst_pending();
        int n;
        n = cyc;
        nmi = 1'b1; model_launch(n, pause);
        tick(); nmi = 1'b0;
        tick(); nmi = 1'b1;
        tick(); nmi = 1'b0;
        tick(); nmi = 1'b1;
        model_launch(n + 4, pause);
        tick(); nmi = 1'b0;
        repeat (8) tick();
    endtask

    // edge exactly in VB_SY: immediate restart
    task automatic burst_sy();
        int n;
        n = cyc;
        nmi = 1'b1; model_launch(n, pause);
        tick(); nmi = 1'b0;
        tick(); tick(); tick();
        nmi = 1'b1;
        model_launch(n + 4, pause);
        tick(); nmi = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        model_reset();
        repeat (3) tick();
        check_reset_vals();

        do_init(2);
        @(negedge clk);
        chk("ready_after_init", ready, 1);
        chk("error_after_init", error, 0);
        tick();

        for (int i = 0; i < 200; i++)
            frame_pulse($urandom_range(0, 3) == 0, $urandom_range(4, 8));
        pause = 1'b0;
        burst_pending();
        burst_sy();
        pause = 1'b1;
        burst_pending();
        pause = 1'b0;

        n = cyc;
        nmi = 1'b1;
        model_launch(n, 1'b0);
        tick(); nmi = 1'b0;
        tick();
        do_reset();

        do_init(0);
        @(negedge clk);
        chk("ready_after_reinit", ready, 1);
        tick();
        for (int i = 0; i < 40; i++)
            frame_pulse($urandom_range(0, 3) == 0, $urandom_range(4, 8));

        do_reset();
        do_init(1000);
        repeat (2) tick();
        @(negedge clk);
        chk("error_set", error, 1);
        chk("error_ready", ready, 0);
        tick();
        repeat (3) begin
            nmi = 1'b1; tick();
            nmi = 1'b0; repeat (6) tick();
        end
        @(negedge clk);
        chk("error_frame", frame_cnt, 0);
        chk("error_idle_bus", {7'd0, bus.rw, bus.addr, bus.data_o}, {7'd0, 1'b1, 24'd0});

        repeat (10) tick();
        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
